// File: rtl/dphy_pkg.sv
// Shared types and constants for the D-PHY data-lane transmit path.
package dphy_pkg;

    // Burst sequencer states, in the order a burst walks through them.
    typedef enum logic [2:0] {
        STOP,
        HS_RQST,
        HS_PREPARE,
        HS_ZERO,
        SYNC,
        PAYLOAD,
        HS_TRAIL,
        HS_EXIT
    } dlane_state_t;

    // Leader sequence sent LSB first: 0,0,0,1,1,1,0,1.
    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    // LP line-pair levels, packed as {lpp, lpn}.
    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

endpackage

// File: rtl/dlane_tx_seq_if.sv
// PPI-style byte interface between the protocol layer and the lane sequencer.
interface dlane_tx_seq_if;

    logic       tx_request_hs;
    logic [7:0] tx_data;
    logic       tx_ready_hs;

    modport master (output tx_request_hs, output tx_data, input tx_ready_hs);
    modport slave  (input tx_request_hs, input tx_data, output tx_ready_hs);

endinterface

// File: rtl/dlane_hs_serializer.sv
// HS byte serializer: shift register, bit counter and trail-level latch.
module dlane_hs_serializer
    import dphy_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_sync,
    input  logic       load_data,
    input  logic [7:0] data_in,
    input  logic       shift_en,
    input  logic       latch_trail,
    output logic       hs_bit,
    output logic       byte_end,
    output logic       trail
);

    logic [7:0] sr_reg;
    logic [2:0] bit_cnt_reg;
    logic       trail_reg;

    // Load a new byte or shift one bit out per cycle; capture the trail level
    // as the inverse of the last bit on the wire.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_reg      <= '0;
            bit_cnt_reg <= '0;
            trail_reg   <= 1'b0;
        end else begin
            if (load_sync) begin
                sr_reg      <= SYNC_BYTE;
                bit_cnt_reg <= '0;
            end else if (load_data) begin
                sr_reg      <= data_in;
                bit_cnt_reg <= '0;
            end else if (shift_en) begin
                sr_reg      <= {1'b0, sr_reg[7:1]};
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
            if (latch_trail) begin
                trail_reg <= ~sr_reg[0];
            end
        end
    end

    assign hs_bit   = sr_reg[0];
    assign byte_end = (bit_cnt_reg == 3'd7);
    assign trail    = trail_reg;

endmodule

// File: rtl/dlane_tx_seq.sv
// D-PHY data-lane transmit sequencer: LP-11 -> LP-01 -> LP-00 -> HS burst -> LP-11.
module dlane_tx_seq
    import dphy_pkg::*;
#(
    parameter int T_LPX        = 4,
    parameter int T_HS_PREPARE = 4,
    parameter int T_HS_ZERO    = 10,
    parameter int T_HS_TRAIL   = 8,
    parameter int T_HS_EXIT    = 8,
    parameter int CNT_W        = 8
) (
    input  logic           clk,
    input  logic           rst,
    dlane_tx_seq_if.slave  ppi,
    output logic           lpp,
    output logic           lpn,
    output logic           hs,
    output logic           s,
    output logic           stop_state
);

    dlane_state_t     state_reg, state_next;
    logic [CNT_W-1:0] timer_reg, timer_next;

    logic load_sync, load_data, latch_trail, shift_en;
    logic ser_bit, byte_end, trail;
    logic in_byte;

    // Timer reload value for a state: each timed state lasts exactly N cycles.
    function automatic logic [CNT_W-1:0] dur(input dlane_state_t st);
        case (st)
            HS_RQST:    dur = CNT_W'(T_LPX - 1);
            HS_PREPARE: dur = CNT_W'(T_HS_PREPARE - 1);
            HS_ZERO:    dur = CNT_W'(T_HS_ZERO - 1);
            HS_TRAIL:   dur = CNT_W'(T_HS_TRAIL - 1);
            HS_EXIT:    dur = CNT_W'(T_HS_EXIT - 1);
            default:    dur = '0;
        endcase
    endfunction

    assign in_byte  = (state_reg == SYNC) || (state_reg == PAYLOAD);
    assign shift_en = in_byte;

    // State and timer registers; reset aborts straight to LP-11.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= STOP;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
        end
    end

    // Next-state logic, serializer strobes and timer reload on state entry.
    always_comb begin
        state_next  = state_reg;
        timer_next  = (timer_reg == '0) ? '0 : timer_reg - 1'b1;
        load_sync   = 1'b0;
        load_data   = 1'b0;
        latch_trail = 1'b0;
        case (state_reg)
            STOP:       if (ppi.tx_request_hs) state_next = HS_RQST;
            HS_RQST:    if (timer_reg == '0) state_next = HS_PREPARE;
            HS_PREPARE: if (timer_reg == '0) state_next = HS_ZERO;
            HS_ZERO: begin
                if (timer_reg == '0) begin
                    state_next = SYNC;
                    load_sync  = 1'b1;
                end
            end
            SYNC, PAYLOAD: begin
                if (byte_end) begin
                    if (ppi.tx_request_hs) begin
                        state_next = PAYLOAD;
                        load_data  = 1'b1;
                    end else begin
                        state_next  = HS_TRAIL;
                        latch_trail = 1'b1;
                    end
                end
            end
            HS_TRAIL:   if (timer_reg == '0) state_next = HS_EXIT;
            HS_EXIT:    if (timer_reg == '0) state_next = STOP;
            default:    state_next = STOP;
        endcase
        if (state_next != state_reg) begin
            timer_next = dur(state_next);
        end
    end

    // Moore decode of the lane levels from registered state and shift register.
    always_comb begin
        {lpp, lpn} = LP00;
        hs         = 1'b0;
        s          = 1'b0;
        stop_state = 1'b0;
        case (state_reg)
            STOP:          begin {lpp, lpn} = LP11; stop_state = 1'b1; end
            HS_RQST:       {lpp, lpn} = LP01;
            HS_PREPARE:    {lpp, lpn} = LP00;
            HS_ZERO:       s = 1'b1;
            SYNC, PAYLOAD: begin s = 1'b1; hs = ser_bit; end
            HS_TRAIL:      begin s = 1'b1; hs = trail; end
            HS_EXIT:       {lpp, lpn} = LP11;
            default:       {lpp, lpn} = LP11;
        endcase
    end

    assign ppi.tx_ready_hs = in_byte && byte_end && ppi.tx_request_hs;

    dlane_hs_serializer u_ser (
        .clk         (clk),
        .rst         (rst),
        .load_sync   (load_sync),
        .load_data   (load_data),
        .data_in     (ppi.tx_data),
        .shift_en    (shift_en),
        .latch_trail (latch_trail),
        .hs_bit      (ser_bit),
        .byte_end    (byte_end),
        .trail       (trail)
    );

endmodule

// File: tb/tb_dlane_tx_seq.sv
// Directed bench for the data-lane transmit sequencer.
module tb_dlane_tx_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dlane_tx_seq_if ppi_a ();
    dlane_tx_seq_if ppi_b ();

    logic lpp_a, lpn_a, hs_a, s_a, stop_a;
    logic lpp_b, lpn_b, hs_b, s_b, stop_b;

    dlane_tx_seq #(
        .T_LPX(2), .T_HS_PREPARE(2), .T_HS_ZERO(3), .T_HS_TRAIL(2), .T_HS_EXIT(2), .CNT_W(8)
    ) dut_a (
        .clk(clk), .rst(rst), .ppi(ppi_a),
        .lpp(lpp_a), .lpn(lpn_a), .hs(hs_a), .s(s_a), .stop_state(stop_a)
    );

    dlane_tx_seq dut_b (
        .clk(clk), .rst(rst), .ppi(ppi_b),
        .lpp(lpp_b), .lpn(lpn_b), .hs(hs_b), .s(s_b), .stop_state(stop_b)
    );

    typedef struct {
        logic       req;
        logic [7:0] data;
        logic       lpp;
        logic       lpn;
        logic       s;
        logic       hs;
        logic       rdy;
        logic       stop;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic req, input logic [7:0] d, input logic lpp,
                                input logic lpn, input logic s, input logic hs,
                                input logic rdy, input logic stop);
        vec_t v;
        v.req = req; v.data = d; v.lpp = lpp; v.lpn = lpn;
        v.s = s; v.hs = hs; v.rdy = rdy; v.stop = stop;
        vecs.push_back(v);
    endfunction

    function automatic void addn(input int n, input logic req, input logic lpp, input logic lpn,
                                 input logic s, input logic hs, input logic stop);
        for (int i = 0; i < n; i++) add(req, 8'h00, lpp, lpn, s, hs, 1'b0, stop);
    endfunction

    // One clock cycle: drive inputs just after the edge, settle, then sample.
    task automatic step(input logic req, input logic [7:0] d);
        @(posedge clk);
        #1;
        ppi_a.tx_request_hs = req;
        ppi_a.tx_data       = d;
        #1;
    endtask

    logic [7:0] sync_b = 8'hB8;
    logic [7:0] a5_b   = 8'hA5;
    logic [7:0] bytes [3];

    initial begin
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
        ppi_a.tx_request_hs = 1'b0; ppi_a.tx_data = 8'h00;
        ppi_b.tx_request_hs = 1'b0; ppi_b.tx_data = 8'h00;

        // Single byte 0xA5, request dropped after the first ready pulse.
        add(1, 8'h00, 1, 1, 0, 0, 0, 1);
        addn(2, 1, 0, 1, 0, 0, 0);
        addn(2, 1, 0, 0, 0, 0, 0);
        addn(3, 1, 1'bx, 1'bx, 1, 0, 0);
        for (int i = 0; i < 8; i++) add(1, 8'hA5, 1'bx, 1'bx, 1, sync_b[i], (i == 7), 0);
        for (int i = 0; i < 8; i++) add(0, 8'h00, 1'bx, 1'bx, 1, a5_b[i], 0, 0);
        addn(2, 0, 1'bx, 1'bx, 1, 0, 0);
        addn(2, 0, 1, 1, 0, 0, 0);
        addn(1, 0, 1, 1, 0, 0, 1);
        // One-cycle pulse: sync-only burst, trail 0, no ready pulse.
        add(1, 8'h00, 1, 1, 0, 0, 0, 1);
        addn(2, 0, 0, 1, 0, 0, 0);
        addn(2, 0, 0, 0, 0, 0, 0);
        addn(3, 0, 1'bx, 1'bx, 1, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 8'h00, 1'bx, 1'bx, 1, sync_b[i], 0, 0);
        // Request raised in trail and held: exit, one STOP cycle, next request.
        addn(2, 1, 1'bx, 1'bx, 1, 0, 0);
        addn(2, 1, 1, 1, 0, 0, 0);
        addn(1, 1, 1, 1, 0, 0, 1);
        addn(2, 1, 0, 1, 0, 0, 0);
        addn(2, 1, 0, 0, 0, 0, 0);
        addn(3, 1, 1'bx, 1'bx, 1, 0, 0);
        for (int i = 0; i < 8; i++)
            add((i != 7), 8'h00, 1'bx, 1'bx, 1, sync_b[i], 0, 0);
        addn(2, 0, 1'bx, 1'bx, 1, 0, 0);
        addn(2, 0, 1, 1, 0, 0, 0);
        addn(1, 0, 1, 1, 0, 0, 1);

        // Reset state while reset is held.
        #2;
        chk("rst_lpp", lpp_a, 1); chk("rst_lpn", lpn_a, 1); chk("rst_s", s_a, 0);
        chk("rst_hs", hs_a, 0); chk("rst_rdy", ppi_a.tx_ready_hs, 0); chk("rst_stop", stop_a, 1);
        #10 rst = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].req, vecs[k].data);
            $display("vec %0d req=%0b lp=%0b%0b s=%0b hs=%0b rdy=%0b stop=%0b", k, vecs[k].req,
                     lpp_a, lpn_a, s_a, hs_a, ppi_a.tx_ready_hs, stop_a);
            if (!$isunknown(vecs[k].lpp)) chk($sformatf("vec%0d_lpp", k), lpp_a, vecs[k].lpp);
            if (!$isunknown(vecs[k].lpn)) chk($sformatf("vec%0d_lpn", k), lpn_a, vecs[k].lpn);
            chk($sformatf("vec%0d_s", k), s_a, vecs[k].s);
            chk($sformatf("vec%0d_hs", k), hs_a, vecs[k].hs);
            chk($sformatf("vec%0d_rdy", k), ppi_a.tx_ready_hs, vecs[k].rdy);
            chk($sformatf("vec%0d_stop", k), stop_a, vecs[k].stop);
        end

        // Back-to-back bytes with request held; ready exactly every 8 cycles.
        begin
            int n = 0;
            bit seen = 0;
            while (!seen && n < 40) begin
                step(1, 8'h00);
                seen = ppi_a.tx_ready_hs;
                n++;
            end
            chk("b2b_first_ready_seen", {7'd0, seen}, 8'd1);
            for (int b = 0; b < 3; b++) begin
                logic [7:0] got = 8'h00;
                for (int i = 0; i < 8; i++) begin
                    step(!(b == 2 && i == 7), (b < 2) ? bytes[b + 1] : 8'h00);
                    got[i] = hs_a;
                    chk($sformatf("b2b%0d_s%0d", b, i), s_a, 1);
                    chk($sformatf("b2b%0d_rdy%0d", b, i), ppi_a.tx_ready_hs, (i == 7 && b < 2));
                end
                $display("b2b byte %0d sent %0h", b, got);
                chk($sformatf("b2b%0d_byte", b), got, bytes[b]);
            end
            for (int i = 0; i < 2; i++) begin
                step(0, 8'h00);
                chk($sformatf("b2b_trail_s%0d", i), s_a, 1);
                chk($sformatf("b2b_trail_hs%0d", i), hs_a, 1);
            end
            step(0, 8'h00);
            chk("b2b_exit_s", s_a, 0);
            chk("b2b_exit_lp", {6'd0, lpp_a, lpn_a}, 8'd3);
            step(0, 8'h00);
            step(0, 8'h00);
            chk("b2b_stop", stop_a, 1);
        end

        // Asynchronous reset in the middle of a payload byte.
        begin
            int n = 0;
            bit seen = 0;
            while (!seen && n < 40) begin
                step(1, 8'h5A);
                seen = ppi_a.tx_ready_hs;
                n++;
            end
            chk("arst_ready_seen", {7'd0, seen}, 8'd1);
            step(0, 8'h00);
            step(0, 8'h00);
            chk("arst_pre_s", s_a, 1);
            chk("arst_pre_stop", stop_a, 0);
            #3 rst = 1'b0;
            #1;
            $display("async reset applied lp=%0b%0b s=%0b stop=%0b", lpp_a, lpn_a, s_a, stop_a);
            chk("arst_lpp", lpp_a, 1); chk("arst_lpn", lpn_a, 1); chk("arst_s", s_a, 0);
            chk("arst_hs", hs_a, 0); chk("arst_rdy", ppi_a.tx_ready_hs, 0);
            chk("arst_stop", stop_a, 1);
            @(negedge clk);
            rst = 1'b1;
        end

        // Default timing: measure every timed state on the second instance.
        begin
            int rq = 0, pr = 0, hs_tot = 0, run0 = 0, ex = 0;
            bit done = 0;
            @(posedge clk); #1; ppi_b.tx_request_hs = 1'b1;
            @(posedge clk); #1; ppi_b.tx_request_hs = 1'b0;
            for (int c = 0; c < 80 && !done; c++) begin
                #1;
                if (!s_b && !lpp_b && lpn_b) rq++;
                else if (!s_b && !lpp_b && !lpn_b) pr++;
                else if (s_b) begin
                    hs_tot++;
                    run0 = hs_b ? 0 : run0 + 1;
                end else if (lpp_b && lpn_b && !stop_b && hs_tot > 0) ex++;
                else if (stop_b && ex > 0) done = 1;
                @(posedge clk);
            end
            $display("default durations lpx=%0d prep=%0d zero=%0d trail=%0d exit=%0d",
                     rq, pr, hs_tot - 8 - run0, run0, ex);
            chk("dflt_done", {7'd0, done}, 8'd1);
            chk("dflt_lpx", rq[7:0], 8'd4);
            chk("dflt_prepare", pr[7:0], 8'd4);
            chk("dflt_zero", 8'(hs_tot - 8 - run0), 8'd10);
            chk("dflt_trail", run0[7:0], 8'd8);
            chk("dflt_exit", ex[7:0], 8'd8);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dlane_tx_seq.md
Name: dlane_tx_seq

Overview:
Data-lane transmit sequencer for the D-PHY data lane. It sits directly upstream of the lane output stage and drives its lpp, lpn, hs and s inputs. The block takes a PPI-style byte interface (tx_request_hs, tx_data, tx_ready_hs) and runs the full low-power to high-speed to low-power burst sequence. The sequence is LP-11, LP-01, LP-00, HS-zero, sync byte, serialized payload, trail, then back to LP-11. It emits one HS bit per clk.

Parameters:
T_LPX, 4, cycles in LP-01 (HS request)
T_HS_PREPARE, 4, cycles in LP-00
T_HS_ZERO, 10, cycles driving HS-0 before sync
T_HS_TRAIL, 8, cycles driving trail level after last bit
T_HS_EXIT, 8, cycles in LP-11 before a new burst may start
CNT_W, 8, timer width; every T_* must be in 1..2^CNT_W

Ports:
clk  in  1  bit clock; one HS bit per cycle
rst  in  1  asynchronous, active-low reset
tx_request_hs  in  1  burst request; high holds the burst open
tx_data  in  8  payload byte; sampled only when tx_ready_hs=1
tx_ready_hs  out  1  byte accepted on this edge
lpp  out  1  LP positive-line level to output stage
lpn  out  1  LP negative-line level to output stage
hs  out  1  serial HS bit to output stage
s  out  1  1 = HS mode, 0 = LP mode
stop_state  out  1  lane idle in LP-11 (state STOP)

Behaviour:
- Reset (rst=0, async): state=STOP; lpp=1, lpn=1, hs=0, s=0, tx_ready_hs=0, stop_state=1. Reset mid-burst aborts immediately to LP-11 with no trail.
- lpp, lpn, hs, s and stop_state are Moore decodes of registered state and shift register. There is no input-to-output combinational path on these.
- tx_ready_hs is combinational: (state in {SYNC, PAYLOAD}) && bit_cnt==7 && tx_request_hs.
- A timer loads N-1 on state entry. The state exits on the edge where timer==0, so each timed state lasts exactly N cycles.
- STOP (lpp=1, lpn=1, s=0): on an edge with tx_request_hs=1, go to HS_RQST.
- HS_RQST (lpp=0, lpn=1, s=0) lasts T_LPX cycles, then HS_PREPARE.
- HS_PREPARE (lpp=0, lpn=0, s=0) lasts T_HS_PREPARE cycles, then HS_ZERO.
- HS_ZERO (s=1, hs=0) lasts T_HS_ZERO cycles. On exit, load sr=8'hB8 and bit_cnt=0, then go to SYNC.
- SYNC (s=1, hs=sr[0]): shift right each cycle, sending bits 0,0,0,1,1,1,0,1.
- At bit_cnt==7 in SYNC or PAYLOAD:
  - If tx_request_hs=1: sr<=tx_data, bit_cnt<=0, go to PAYLOAD.
  - Otherwise: latch trail=~sr[0] (inverse of the last bit sent) and go to HS_TRAIL.
- Back-to-back bytes therefore have no gap. tx_ready_hs pulses exactly every 8 cycles.
- PAYLOAD (s=1, hs=sr[0]) sends bits LSB first.
- HS_TRAIL (s=1, hs=trail) lasts T_HS_TRAIL cycles, then HS_EXIT.
- HS_EXIT (lpp=1, lpn=1, s=0) lasts T_HS_EXIT cycles, then STOP. tx_request_hs is ignored here.
- In LP states hs=0.
- Request dropping during HS_RQST, HS_PREPARE or HS_ZERO is ignored. The sequence still sends sync, then trails; a zero-payload burst is legal.
- Request dropping mid-byte has no effect until bit_cnt==7; the current byte always completes.
- If the request is held high through HS_EXIT, STOP lasts exactly 1 cycle before HS_RQST.

Decomposition:
- Package dphy_pkg holds:
  - the state enum (STOP, HS_RQST, HS_PREPARE, HS_ZERO, SYNC, PAYLOAD, HS_TRAIL, HS_EXIT);
  - SYNC_BYTE=8'hB8;
  - LP line-pair constants LP11/LP01/LP00.
- One sub-module, dlane_hs_serializer, holds the 8-bit shift register, the 3-bit bit_cnt, the load strobe and the last-bit/trail latch. The FSM and timer stay in the top.

Test Plan:
1. Reset: drive rst=0 mid-PAYLOAD with no clk edge -> lpp=1, lpn=1, s=0, hs=0, tx_ready_hs=0, stop_state=1 immediately.
2. Single byte, with T_LPX=2, T_HS_PREPARE=2, T_HS_ZERO=3, T_HS_TRAIL=2, T_HS_EXIT=2; tx_request_hs=1, tx_data=0xA5, request dropped after the first tx_ready_hs. Expected response, in order:
   - LP-01 for 2 cycles, LP-00 for 2 cycles, s=1 with hs=0 for 3 cycles;
   - hs=0,0,0,1,1,1,0,1 with tx_ready_hs high on the 8th of those cycles;
   - hs=1,0,1,0,0,1,0,1;
   - trail hs=0 for 2 cycles;
   - LP-11 with s=0 for 2 cycles, then stop_state=1.
3. Back-to-back bytes 0x00, 0xFF, 0x3C, request held throughout -> tx_ready_hs pulses exactly 8 cycles apart with no bubble; last bit 0 gives trail hs=1.
4. 1-cycle request pulse in STOP -> complete burst with sync only, trail hs=0, no tx_ready_hs pulse.
5. Request held high continuously across two bursts -> STOP lasts exactly 1 cycle between HS_EXIT and HS_RQST.
6. Default parameters -> state durations measured as exactly 4, 4, 10, 8, 8 cycles.
